// File: rtl/seq10110_pkg.sv
// Shared state encoding and pattern constant for the 10110 sequence detectors.
package seq10110_pkg;

    localparam int unsigned PAT_LEN = 5;
    localparam logic [PAT_LEN-1:0] PATTERN = 5'b10110;

    // State name records the prefix of PATTERN matched so far; S5 is a full match.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_e;

endpackage : seq10110_pkg

// File: rtl/mealy_10110_fsm.sv
// Mealy detector for 10110: w rises in the same cycle the final 0 is on j.
module mealy_10110_fsm
    import seq10110_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic w
);

    state_e state_q;
    state_e state_d;

    // State register, asynchronously cleared to S0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and detect; a match falls back to S2 to keep the trailing "10".
    always_comb begin
        state_d = S0;
        w       = 1'b0;
        case (state_q)
            S0:      state_d = j ? S1 : S0;
            S1:      state_d = j ? S1 : S2;
            S2:      state_d = j ? S3 : S0;
            S3:      state_d = j ? S4 : S2;
            S4: begin
                state_d = j ? S1 : S2;
                w       = (j == PATTERN[0]);
            end
            default: state_d = S0;
        endcase
    end

endmodule : mealy_10110_fsm

// File: rtl/moore_10110_fsm.sv
// Moore detector for 10110: w is high for the one cycle spent in the match state.
module moore_10110_fsm
    import seq10110_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic w
);

    state_e state_q;
    state_e state_d;

    // State register, asynchronously cleared to S0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-only detect; from S5 a 1 extends the retained "10" to "101".
    always_comb begin
        state_d = S0;
        w       = 1'b0;
        case (state_q)
            S0:      state_d = j ? S1 : S0;
            S1:      state_d = j ? S1 : S2;
            S2:      state_d = j ? S3 : S0;
            S3:      state_d = j ? S4 : S2;
            S4:      state_d = (j == PATTERN[0]) ? S5 : S1;
            S5: begin
                state_d = j ? S3 : S0;
                w       = 1'b1;
            end
            default: state_d = S0;
        endcase
    end

endmodule : moore_10110_fsm

// File: rtl/seq_detector_10110.sv
// Top: Mealy and Moore 10110 detectors on one serial input plus their XOR.
module seq_detector_10110
    import seq10110_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic w_mealy,
    output logic w_moore,
    output logic diff
);

    mealy_10110_fsm u_mealy (
        .clk (clk),
        .rst (rst),
        .j   (j),
        .w   (w_mealy)
    );

    moore_10110_fsm u_moore (
        .clk (clk),
        .rst (rst),
        .j   (j),
        .w   (w_moore)
    );

    // Disagreement flag: high for two cycles around each detection.
    assign diff = w_mealy ^ w_moore;

endmodule : seq_detector_10110

// File: tb/tb_seq_detector_10110.sv
// Directed and random checks of the Mealy/Moore 10110 detectors.
module tb_seq_detector_10110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic j   = 1'b0;
    logic w_mealy;
    logic w_moore;
    logic diff;

    int checks   = 0;
    int failures = 0;

    seq_detector_10110 dut (
        .clk     (clk),
        .rst     (rst),
        .j       (j),
        .w_mealy (w_mealy),
        .w_moore (w_moore),
        .diff    (diff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one bit mid-cycle, then check all outputs before the sampling edge.
    task automatic send(input string tag, input logic b, input logic em, input logic eo);
        @(negedge clk);
        j = b;
        #1;
        chk({tag, ".mealy"}, w_mealy, em);
        chk({tag, ".moore"}, w_moore, eo);
        chk({tag, ".diff"},  diff,    em ^ eo);
    endtask

    // Hold reset for three cycles with j toggling; both outputs must stay low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            j = k[0];
            #1;
            chk("reset.mealy", w_mealy, 1'b0);
            chk("reset.moore", w_moore, 1'b0);
            @(negedge clk);
        end
        j   = 1'b0;
        rst = 1'b0;
    endtask

    logic [3:0] hist;
    int         nvalid;
    logic       b;
    logic       exp_m;
    logic       prev_m;
    int         golden;
    int         obs_det;

    initial begin
        // Reset behaviour
        do_reset();
        send("idle", 1'b0, 1'b0, 1'b0);

        // Overlapping stream 0,1,0,1,1,0,1,1,0: Mealy at bits 6 and 9, Moore one cycle later
        send("ov.b1", 1'b0, 1'b0, 1'b0);
        send("ov.b2", 1'b1, 1'b0, 1'b0);
        send("ov.b3", 1'b0, 1'b0, 1'b0);
        send("ov.b4", 1'b1, 1'b0, 1'b0);
        send("ov.b5", 1'b1, 1'b0, 1'b0);
        send("ov.b6", 1'b0, 1'b1, 1'b0);
        send("ov.b7", 1'b1, 1'b0, 1'b1);
        send("ov.b8", 1'b1, 1'b0, 1'b0);
        send("ov.b9", 1'b0, 1'b1, 1'b0);
        send("ov.b10", 1'b0, 1'b0, 1'b1);
        send("ov.b11", 1'b0, 1'b0, 1'b0);

        // Near-miss 1,0,1,1,1,0
        do_reset();
        send("nm1.b1", 1'b1, 1'b0, 1'b0);
        send("nm1.b2", 1'b0, 1'b0, 1'b0);
        send("nm1.b3", 1'b1, 1'b0, 1'b0);
        send("nm1.b4", 1'b1, 1'b0, 1'b0);
        send("nm1.b5", 1'b1, 1'b0, 1'b0);
        send("nm1.b6", 1'b0, 1'b0, 1'b0);
        send("nm1.b7", 1'b0, 1'b0, 1'b0);

        // Near-miss 1,0,0,1,1,0
        do_reset();
        send("nm2.b1", 1'b1, 1'b0, 1'b0);
        send("nm2.b2", 1'b0, 1'b0, 1'b0);
        send("nm2.b3", 1'b0, 1'b0, 1'b0);
        send("nm2.b4", 1'b1, 1'b0, 1'b0);
        send("nm2.b5", 1'b1, 1'b0, 1'b0);
        send("nm2.b6", 1'b0, 1'b0, 1'b0);
        send("nm2.b7", 1'b0, 1'b0, 1'b0);

        // Back-to-back 1,0,1,1,0,1,1,0,1,1,0: detections at bits 5, 8, 11
        do_reset();
        send("bb.b1", 1'b1, 1'b0, 1'b0);
        send("bb.b2", 1'b0, 1'b0, 1'b0);
        send("bb.b3", 1'b1, 1'b0, 1'b0);
        send("bb.b4", 1'b1, 1'b0, 1'b0);
        send("bb.b5", 1'b0, 1'b1, 1'b0);
        send("bb.b6", 1'b1, 1'b0, 1'b1);
        send("bb.b7", 1'b1, 1'b0, 1'b0);
        send("bb.b8", 1'b0, 1'b1, 1'b0);
        send("bb.b9", 1'b1, 1'b0, 1'b1);
        send("bb.b10", 1'b1, 1'b0, 1'b0);
        send("bb.b11", 1'b0, 1'b1, 1'b0);
        send("bb.b12", 1'b0, 1'b0, 1'b1);
        send("bb.b13", 1'b0, 1'b0, 1'b0);

        // Async reset mid-pattern: 1,0,1,1 then rst between edges, then 0
        do_reset();
        send("ar.b1", 1'b1, 1'b0, 1'b0);
        send("ar.b2", 1'b0, 1'b0, 1'b0);
        send("ar.b3", 1'b1, 1'b0, 1'b0);
        send("ar.b4", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        j = 1'b0;
        #1;
        chk("ar.armed.mealy", w_mealy, 1'b1);
        rst = 1'b1;
        #1;
        chk("ar.async.mealy", w_mealy, 1'b0);
        chk("ar.async.moore", w_moore, 1'b0);
        chk("ar.async.diff",  diff,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        send("ar.b5", 1'b0, 1'b0, 1'b0);
        send("ar.b6", 1'b0, 1'b0, 1'b0);

        // Random stream against a sliding-window reference
        do_reset();
        hist    = 4'b0000;
        nvalid  = 0;
        prev_m  = 1'b0;
        golden  = 0;
        obs_det = 0;
        for (int i = 0; i < 1001; i++) begin
            b = (i == 1000) ? 1'b0 : 1'($urandom_range(0, 1));
            exp_m = (nvalid >= 4) && ({hist, b} == 5'b10110);
            send("rand", b, exp_m, prev_m);
            if (w_moore === 1'b1) obs_det++;
            if (i < 1000 && exp_m) golden++;
            prev_m = exp_m;
            hist   = {hist[2:0], b};
            nvalid++;
        end
        checks++;
        assert (obs_det == golden) else begin
            failures++;
            $error("FAIL rand.count: observed=%0d expected=%0d", obs_det, golden);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_detector_10110
